// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register for the MIPS pipeline. Latches the decoded
//   control bundle and operand data each enabled cycle. It detects load-use
//   hazards against the instruction in EX. On a hazard it stalls PC and
//   IF/ID and injects a bubble. On flush it squashes the ID instruction.
//   It counts hazard bubbles with a saturating counter.
//
// Ports
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_enable              0 = hold every register (debug unit)
//   i_flush               squash the instruction currently in ID
//   i_<control>           decoded control of the ID instruction
//   i_branch              ID instruction is BEQ/BNE (reads rt)
//   i_pc_plus4 .. i_rd    operand data and register indices
//   o_<control/data>      registered copies, zero while a bubble is in EX
//   o_valid               1 = real instruction in EX (LOAD), 0 = bubble
//   o_stall               hold PC and IF/ID this cycle (combinational)
//   o_bubble_cnt          saturating count of hazard bubbles
//
// Handshake: there is no valid/ready pair. o_stall is a same-cycle request
// to the upstream stages, sampled by them on the same edge that loads the
// bubble here. i_enable low freezes this stage and the counter entirely.
module id_ex_stage #(
    parameter int NBITS = 32,
    parameter int RBITS = 5,
    parameter int CBITS = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic             i_Reg_write,
    input  logic             i_ALU_source,
    input  logic             i_Mem_write,
    input  logic             i_Mem_to_Reg,
    input  logic             i_Mem_read,
    input  logic             i_Link_flag,
    input  logic [2:0]       i_ALU_op,
    input  logic [1:0]       i_Reg_dst,
    input  logic [4:0]       i_Size_control,
    input  logic             i_branch,
    input  logic [NBITS-1:0] i_pc_plus4,
    input  logic [NBITS-1:0] i_rs_data,
    input  logic [NBITS-1:0] i_rt_data,
    input  logic [NBITS-1:0] i_imm_ext,
    input  logic [RBITS-1:0] i_rs,
    input  logic [RBITS-1:0] i_rt,
    input  logic [RBITS-1:0] i_rd,
    output logic             o_Reg_write,
    output logic             o_ALU_source,
    output logic             o_Mem_write,
    output logic             o_Mem_to_Reg,
    output logic             o_Mem_read,
    output logic             o_Link_flag,
    output logic [2:0]       o_ALU_op,
    output logic [1:0]       o_Reg_dst,
    output logic [4:0]       o_Size_control,
    output logic [NBITS-1:0] o_pc_plus4,
    output logic [NBITS-1:0] o_rs_data,
    output logic [NBITS-1:0] o_rt_data,
    output logic [NBITS-1:0] o_imm_ext,
    output logic [RBITS-1:0] o_rs,
    output logic [RBITS-1:0] o_rt,
    output logic [RBITS-1:0] o_rd,
    output logic             o_valid,
    output logic             o_stall,
    output logic [CBITS-1:0] o_bubble_cnt
);

    // Two-state machine; the state register doubles as o_valid.
    localparam logic [0:0] ST_BUBBLE = 1'b0;
    localparam logic [0:0] ST_LOAD   = 1'b1;

    localparam logic [CBITS-1:0] CNT_MAX = {CBITS{1'b1}};

    logic [0:0]       state_q, state_d;
    logic             reg_write_q, reg_write_d;
    logic             alu_source_q, alu_source_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             mem_read_q, mem_read_d;
    logic             link_flag_q, link_flag_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [1:0]       reg_dst_q, reg_dst_d;
    logic [4:0]       size_control_q, size_control_d;
    logic [NBITS-1:0] pc_plus4_q, pc_plus4_d;
    logic [NBITS-1:0] rs_data_q, rs_data_d;
    logic [NBITS-1:0] rt_data_q, rt_data_d;
    logic [NBITS-1:0] imm_ext_q, imm_ext_d;
    logic [RBITS-1:0] rs_q, rs_d;
    logic [RBITS-1:0] rt_q, rt_d;
    logic [RBITS-1:0] rd_q, rd_d;
    logic [CBITS-1:0] bubble_cnt_q, bubble_cnt_d;

    logic uses_rt;
    logic hazard;
    logic valid_q;

    assign valid_q = (state_q == ST_LOAD);

    // rt is a source for R-type (rd destination), stores and branches; for
    // I-type ALU ops and loads rt is the destination and cannot conflict.
    assign uses_rt = (i_Reg_dst == 2'b10) | i_Mem_write | i_branch;

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign hazard = mem_read_q & valid_q & (rt_q != '0) &
                    ((rt_q == i_rs) | ((rt_q == i_rt) & uses_rt));

    // A squashed ID instruction must not freeze the front end.
    assign o_stall = hazard & ~i_flush;

    always_comb begin
        state_d        = state_q;
        reg_write_d    = reg_write_q;
        alu_source_d   = alu_source_q;
        mem_write_d    = mem_write_q;
        mem_to_reg_d   = mem_to_reg_q;
        mem_read_d     = mem_read_q;
        link_flag_d    = link_flag_q;
        alu_op_d       = alu_op_q;
        reg_dst_d      = reg_dst_q;
        size_control_d = size_control_q;
        pc_plus4_d     = pc_plus4_q;
        rs_data_d      = rs_data_q;
        rt_data_d      = rt_data_q;
        imm_ext_d      = imm_ext_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        bubble_cnt_d   = bubble_cnt_q;

        if (i_enable) begin
            if (i_flush || hazard) begin
                state_d        = ST_BUBBLE;
                reg_write_d    = 1'b0;
                alu_source_d   = 1'b0;
                mem_write_d    = 1'b0;
                mem_to_reg_d   = 1'b0;
                mem_read_d     = 1'b0;
                link_flag_d    = 1'b0;
                alu_op_d       = '0;
                reg_dst_d      = '0;
                size_control_d = '0;
                pc_plus4_d     = '0;
                rs_data_d      = '0;
                rt_data_d      = '0;
                imm_ext_d      = '0;
                rs_d           = '0;
                rt_d           = '0;
                rd_d           = '0;
                // Only real hazard bubbles are counted; flush takes priority.
                if (!i_flush && hazard && (bubble_cnt_q != CNT_MAX)) begin
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
                end
            end else begin
                state_d        = ST_LOAD;
                reg_write_d    = i_Reg_write;
                alu_source_d   = i_ALU_source;
                mem_write_d    = i_Mem_write;
                mem_to_reg_d   = i_Mem_to_Reg;
                mem_read_d     = i_Mem_read;
                link_flag_d    = i_Link_flag;
                alu_op_d       = i_ALU_op;
                reg_dst_d      = i_Reg_dst;
                size_control_d = i_Size_control;
                pc_plus4_d     = i_pc_plus4;
                rs_data_d      = i_rs_data;
                rt_data_d      = i_rt_data;
                imm_ext_d      = i_imm_ext;
                rs_d           = i_rs;
                rt_d           = i_rt;
                rd_d           = i_rd;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= ST_BUBBLE;
            reg_write_q    <= 1'b0;
            alu_source_q   <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            mem_read_q     <= 1'b0;
            link_flag_q    <= 1'b0;
            alu_op_q       <= '0;
            reg_dst_q      <= '0;
            size_control_q <= '0;
            pc_plus4_q     <= '0;
            rs_data_q      <= '0;
            rt_data_q      <= '0;
            imm_ext_q      <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            reg_write_q    <= reg_write_d;
            alu_source_q   <= alu_source_d;
            mem_write_q    <= mem_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            mem_read_q     <= mem_read_d;
            link_flag_q    <= link_flag_d;
            alu_op_q       <= alu_op_d;
            reg_dst_q      <= reg_dst_d;
            size_control_q <= size_control_d;
            pc_plus4_q     <= pc_plus4_d;
            rs_data_q      <= rs_data_d;
            rt_data_q      <= rt_data_d;
            imm_ext_q      <= imm_ext_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign o_Reg_write    = reg_write_q;
    assign o_ALU_source   = alu_source_q;
    assign o_Mem_write    = mem_write_q;
    assign o_Mem_to_Reg   = mem_to_reg_q;
    assign o_Mem_read     = mem_read_q;
    assign o_Link_flag    = link_flag_q;
    assign o_ALU_op       = alu_op_q;
    assign o_Reg_dst      = reg_dst_q;
    assign o_Size_control = size_control_q;
    assign o_pc_plus4     = pc_plus4_q;
    assign o_rs_data      = rs_data_q;
    assign o_rt_data      = rt_data_q;
    assign o_imm_ext      = imm_ext_q;
    assign o_rs           = rs_q;
    assign o_rt           = rt_q;
    assign o_rd           = rd_q;
    assign o_valid        = valid_q;
    assign o_bubble_cnt   = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between instruction decode and execute in the MIPS pipeline. It latches the decoded control bundle and operand data every cycle. It detects load-use hazards against the instruction currently in EX, and on a hazard it stalls PC and IF/ID and injects a bubble. It also squashes the ID instruction on flush, holds state while the debug unit has the pipeline disabled, and counts hazard bubbles for the debug unit.

## Interface
- NBITS, 32, data/PC width
- RBITS, 5, register index width
- CBITS, 16, bubble counter width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_enable  in  1  pipeline advance enable from debug unit; 0 = hold all state
- i_flush  in  1  squash instruction currently in ID
- i_Reg_write, i_ALU_source, i_Mem_write, i_Mem_to_Reg, i_Mem_read, i_Link_flag  in  1 each  decoded control
- i_ALU_op  in  3  ALU operation class
- i_Reg_dst  in  2  destination select (00 rt, 01 r31, 10 rd)
- i_Size_control  in  5  load/store size/sign code
- i_branch  in  1  BEQ_flag | BNE_flag of ID instruction
- i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext  in  NBITS each  operands
- i_rs, i_rt, i_rd  in  RBITS each  register indices
- o_Reg_write … o_Size_control  out  same widths  registered copies of the control inputs
- o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd  out  registered data
- o_valid  out  1  1 = real instruction in EX, 0 = bubble
- o_stall  out  1  hold PC and IF/ID this cycle (combinational)
- o_bubble_cnt  out  CBITS  saturating count of hazard bubbles

## Operation
- Hazard detection is computed from the registered EX fields and the current ID inputs.
  - hazard = o_Mem_read & o_valid & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt & uses_rt))
  - uses_rt = (i_Reg_dst == 2'b10) | i_Mem_write | i_branch
- o_stall = hazard & ~i_flush. A squashed instruction never stalls.
- Register update, by priority:
  1. i_rst: all outputs 0, including o_valid and o_bubble_cnt.
  2. i_enable = 0: every register holds, counter included.
  3. i_flush = 1: load a bubble.
  4. hazard = 1: load a bubble and increment o_bubble_cnt, saturating at 2^CBITS-1.
  5. Otherwise: load all inputs and set o_valid = 1.
- Bubble: all control outputs 0, all data and index outputs 0, o_valid = 0. A bubble writes no register and no memory.
- The block has two states, LOAD and BUBBLE, represented by o_valid. BUBBLE returns to LOAD on the next enabled cycle unless a new flush or hazard occurs.
- A load-use hazard lasts exactly one cycle. After the bubble, o_Mem_read = 0, so a second consecutive hazard from the same load is impossible.

## Timing
- All registered outputs update on the rising edge of i_clk; latency ID→EX is 1 cycle.
- o_stall is combinational and valid in the same cycle as the ID inputs. The consumer samples it at the same edge.
- Asynchronous reset clears outputs immediately, mid-cycle. After deassertion, the first enabled edge loads normally.
- Flush and hazard in the same cycle: one bubble, o_stall = 0, counter unchanged.
- Enable low and hazard in the same cycle: o_stall may assert, nothing is latched, and the counter does not move. The bubble is inserted on the first enabled edge if the hazard still holds.
- Counter at max plus a hazard: the counter stays at max.
- A hazard against r0 is never flagged.

## Test plan
- Reset: assert i_rst mid-cycle with valid data present → all outputs 0 asynchronously and o_bubble_cnt = 0.
- Normal flow: ADDI (i_Reg_write=1, i_ALU_source=1, i_ALU_op=001, i_rt=8, i_imm_ext=5) → next edge o_valid=1, o_ALU_op=001, o_rt=8, o_imm_ext=5, o_stall=0.
- Load-use stall:
  - Stimulus: LW with i_rt=9, then ADD (i_rs=9, i_Reg_dst=10).
  - Response: o_stall=1 for exactly 1 cycle; EX holds a bubble (o_valid=0, o_Reg_write=0); o_bubble_cnt=1; the ADD is latched on the following edge.
- Rt usage rule:
  - LW with i_rt=9 followed by ADDI with i_rt=9 → no stall.
  - LW with i_rt=9 followed by SW with i_rt=9 → stall.
  - LW with i_rt=0 followed by any instruction using r0 → no stall.
- Flush versus hazard: LW with i_rt=9 followed by ADD with i_rs=9 and i_flush=1 → o_stall=0, bubble latched, o_bubble_cnt unchanged.
- Enable and saturation:
  - i_enable=0 for 3 cycles with changing inputs → outputs frozen.
  - With CBITS=2, 5 hazards → o_bubble_cnt=3.
